fetch_ctrl: RTL

//  Sequences the fetch stage: drives PC-select, fetch stall and decode flush for the fetch unit.

---
 rtl/fetch_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: merges stalls, memory wait states, redirects and halt into
// PC-select, fetch stall and decode flush controls.
module fetch_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             FC_CLK,
    input  logic             FC_RST,
    input  logic             FC_HazStall,
    input  logic             FC_ImemReady,
    input  logic             FC_BranchTkn,
    input  logic [WIDTH-1:0] FC_PcBranch,
    input  logic             FC_Jump,
    input  logic [WIDTH-1:0] FC_PcJump,
    input  logic             FC_Halt,
    output logic [1:0]       FC_PcSrc,
    output logic [WIDTH-1:0] FC_PcTarget,
    output logic             FC_StallF,
    output logic             FC_FlushD,
    output logic             FC_Busy,
    output logic             FC_MemErr
);

    localparam int unsigned BW = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StBoot,
        StRun,
        StWait,
        StPend,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
    logic [1:0]       pend_src_q, pend_src_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic             redirect;
    logic [1:0]       redir_src;
    logic [WIDTH-1:0] redir_tgt;
    logic             stall;
    logic [TW-1:0]    tmo_inc;
    logic             tmo_hit;

    // Branch has priority over a simultaneous jump; the jump is dropped.
    always_comb begin
        redirect  = FC_BranchTkn | FC_Jump;
        redir_src = 2'b00;
        redir_tgt = '0;
        if (FC_BranchTkn) begin
            redir_src = 2'b01;
            redir_tgt = FC_PcBranch;
        end else if (FC_Jump) begin
            redir_src = 2'b10;
            redir_tgt = FC_PcJump;
        end
    end

    always_comb begin
        stall   = FC_HazStall | ~FC_ImemReady;
        tmo_inc = (tmo_cnt_q == TW'(MEM_TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        // Timeout fires in the cycle that would be the MEM_TIMEOUT-th consecutive not-ready one.
        tmo_hit = ~FC_ImemReady && (tmo_inc == TW'(MEM_TIMEOUT)) &&
                  (state_q inside {StRun, StWait, StPend});
    end

    always_ff @(posedge FC_CLK) begin
        if (FC_RST) begin
            state_q    <= StBoot;
            boot_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            pend_src_q <= 2'b00;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q | tmo_hit;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            StBoot: begin
                tmo_cnt_d  = '0;
                boot_cnt_d = (boot_cnt_q == BW'(BOOT_CYCLES)) ? boot_cnt_q : boot_cnt_q + 1'b1;
                if (boot_cnt_q >= BW'(BOOT_CYCLES - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                tmo_cnt_d = FC_ImemReady ? '0 : tmo_inc;
                if (FC_Halt) begin
                    state_d = StHalt;
                end else if (stall && redirect) begin
                    state_d    = StPend;
                    pend_src_d = redir_src;
                    pend_tgt_d = redir_tgt;
                end else if (!FC_ImemReady) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                tmo_cnt_d = FC_ImemReady ? '0 : tmo_inc;
                if (FC_Halt || tmo_hit) begin
                    state_d = StHalt;
                end else if (redirect) begin
                    state_d    = StPend;
                    pend_src_d = redir_src;
                    pend_tgt_d = redir_tgt;
                end else if (FC_ImemReady) begin
                    state_d = StRun;
                end
            end
            StPend: begin
                tmo_cnt_d = FC_ImemReady ? '0 : tmo_inc;
                if (FC_Halt || tmo_hit) begin
                    state_d = StHalt;
                end else if (!stall) begin
                    state_d    = StRun;
                    pend_src_d = 2'b00;
                    pend_tgt_d = '0;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Default is the fully stopped condition: hold PC, flush decode, select PC+4.
    always_comb begin
        FC_PcSrc    = 2'b00;
        FC_PcTarget = '0;
        FC_StallF   = 1'b1;
        FC_FlushD   = 1'b1;
        FC_Busy     = (state_q != StRun);
        FC_MemErr   = err_q | tmo_hit;
        case (state_q)
            StRun: begin
                if (!FC_Halt) begin
                    if (!stall) begin
                        FC_StallF   = 1'b0;
                        FC_FlushD   = redirect;
                        FC_PcSrc    = redir_src;
                        FC_PcTarget = redir_tgt;
                    end else begin
                        FC_FlushD = redirect;
                    end
                end
            end
            StWait: begin
                if (!FC_Halt) begin
                    FC_FlushD = 1'b0;
                end
            end
            StPend: begin
                if (!FC_Halt && !stall) begin
                    FC_StallF   = 1'b0;
                    FC_PcSrc    = pend_src_q;
                    FC_PcTarget = pend_tgt_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
